// File: rtl/act_writeback.sv
// Activation writeback: per-lane FIFOs round-robin arbitrated into the ofmap buffer, FC lane bypassed.
// Optional ACT_WB_DROP_CNT_EN adds a saturating 16-bit dropped-entry counter output drop_cnt_o.
module act_writeback #(
    parameter int LANE_NUM      = 16,
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start_i,
    input  logic [LANE_NUM:0]                         act_valid_i,
    input  logic [LANE_NUM:0]                         act_last_i,
    input  logic [(LANE_NUM+1)*DATA_WIDTH-1:0]        act_result_i,
    input  logic [LANE_NUM*ADDRESS_WIDTH-1:0]         act_result_address_i,
    output logic                                      obuf_wren_o,
    output logic [ADDRESS_WIDTH+$clog2(LANE_NUM)-1:0] obuf_waddr_o,
    output logic [DATA_WIDTH-1:0]                     obuf_wdata_o,
    output logic                                      fc_wren_o,
    output logic [6:0]                                fc_waddr_o,
    output logic [DATA_WIDTH-1:0]                     fc_wdata_o,
    output logic                                      done_o,
    output logic                                      fc_done_o,
    output logic                                      overflow_o
`ifdef ACT_WB_DROP_CNT_EN
    ,
    output logic [15:0]                               drop_cnt_o
`endif
);

    localparam int LANE_W  = $clog2(LANE_NUM);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;
    localparam int WADDR_W = ADDRESS_WIDTH + LANE_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [LANE_NUM-1:0]   last_q, last_d;
    logic                  overflow_q, overflow_d;
    logic [LANE_W-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]      cnt_q [LANE_NUM];
    logic [CNT_W-1:0]      cnt_d [LANE_NUM];
    logic [PTR_W-1:0]      wptr_q [LANE_NUM];
    logic [PTR_W-1:0]      wptr_d [LANE_NUM];
    logic [PTR_W-1:0]      rptr_q [LANE_NUM];
    logic [PTR_W-1:0]      rptr_d [LANE_NUM];
    logic [ENTRY_W-1:0]    mem_q [LANE_NUM][FIFO_DEPTH];
    logic [ENTRY_W-1:0]    head [LANE_NUM];
    logic [LANE_NUM-1:0]   empty, full, push, pop, drop;
    logic                  grant_vld;
    logic [LANE_W-1:0]     grant_idx;
    logic [ENTRY_W-1:0]    grant_entry;
    logic                  active, start_run;

    logic                  obuf_wren_q, obuf_wren_d;
    logic [WADDR_W-1:0]    obuf_waddr_q, obuf_waddr_d;
    logic [DATA_WIDTH-1:0] obuf_wdata_q, obuf_wdata_d;
    logic                  fc_wren_q, fc_wren_d;
    logic [6:0]            fc_waddr_q, fc_waddr_d;
    logic [6:0]            fc_cnt_q, fc_cnt_d;
    logic [DATA_WIDTH-1:0] fc_wdata_q, fc_wdata_d;
    logic                  fc_done_q, fc_done_d;

    assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign start_run = (state_q == S_IDLE) && start_i;

    always_comb begin
        for (int i = 0; i < LANE_NUM; i++) begin
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
            head[i]  = mem_q[i][rptr_q[i]];
        end
    end

    // Round-robin: first non-empty lane at or after rr_q wins.
    always_comb begin : arbiter
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = rr_q;
        for (int k = 0; k < LANE_NUM; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= LANE_NUM) idx = idx - LANE_NUM;
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant_idx = LANE_W'(idx);
            end
        end
    end

    assign grant_entry = head[grant_idx];

    // A full FIFO still accepts when its head leaves in the same cycle.
    always_comb begin
        push = '0;
        pop  = '0;
        drop = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            pop[i]    = grant_vld && (grant_idx == LANE_W'(i));
            push[i]   = active && act_valid_i[i] && (!full[i] || pop[i]);
            drop[i]   = active && act_valid_i[i] && full[i] && !pop[i];
            cnt_d[i]  = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            wptr_d[i] = wptr_q[i] + PTR_W'(push[i]);
            rptr_d[i] = rptr_q[i] + PTR_W'(pop[i]);
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q | (push & act_last_i[LANE_NUM-1:0]);
        overflow_d = overflow_q | (|drop);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_RUN;
                    last_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            S_RUN:   if (&last_q) state_d = S_DRAIN;
            S_DRAIN: if ((&empty) && !obuf_wren_q && !(|push)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_d         = rr_q;
        obuf_wren_d  = grant_vld;
        obuf_waddr_d = obuf_waddr_q;
        obuf_wdata_d = obuf_wdata_q;
        if (grant_vld) begin
            rr_d         = (grant_idx == LANE_W'(LANE_NUM - 1)) ? '0 : grant_idx + 1'b1;
            obuf_waddr_d = {grant_idx, grant_entry[ENTRY_W-1:DATA_WIDTH]};
            obuf_wdata_d = grant_entry[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        fc_wren_d  = act_valid_i[LANE_NUM];
        fc_done_d  = act_valid_i[LANE_NUM] && act_last_i[LANE_NUM];
        fc_waddr_d = fc_waddr_q;
        fc_wdata_d = fc_wdata_q;
        fc_cnt_d   = fc_cnt_q;
        if (act_valid_i[LANE_NUM]) begin
            fc_waddr_d = fc_cnt_q;
            fc_wdata_d = act_result_i[LANE_NUM*DATA_WIDTH +: DATA_WIDTH];
            fc_cnt_d   = act_last_i[LANE_NUM] ? 7'd0 : fc_cnt_q + 7'd1;
        end
        if (start_run) fc_cnt_d = 7'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_q       <= '0;
            overflow_q   <= 1'b0;
            rr_q         <= '0;
            obuf_wren_q  <= 1'b0;
            obuf_waddr_q <= '0;
            obuf_wdata_q <= '0;
            fc_wren_q    <= 1'b0;
            fc_waddr_q   <= '0;
            fc_wdata_q   <= '0;
            fc_done_q    <= 1'b0;
            fc_cnt_q     <= '0;
            for (int i = 0; i < LANE_NUM; i++) begin
                cnt_q[i]  <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            overflow_q   <= overflow_d;
            rr_q         <= rr_d;
            obuf_wren_q  <= obuf_wren_d;
            obuf_waddr_q <= obuf_waddr_d;
            obuf_wdata_q <= obuf_wdata_d;
            fc_wren_q    <= fc_wren_d;
            fc_waddr_q   <= fc_waddr_d;
            fc_wdata_q   <= fc_wdata_d;
            fc_done_q    <= fc_done_d;
            fc_cnt_q     <= fc_cnt_d;
            for (int i = 0; i < LANE_NUM; i++) begin
                cnt_q[i]  <= cnt_d[i];
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
        end
    end

    // Storage is not reset; emptied pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANE_NUM; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= {act_result_address_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                                        act_result_i[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

`ifdef ACT_WB_DROP_CNT_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] drop_cnt_q, drop_cnt_d, n_drop;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < LANE_NUM; i++) n_drop = n_drop + 16'(drop[i]);
        drop_cnt_d = start_run ? 16'd0 : sat_add16(drop_cnt_q, n_drop);
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign obuf_wren_o  = obuf_wren_q;
    assign obuf_waddr_o = obuf_waddr_q;
    assign obuf_wdata_o = obuf_wdata_q;
    assign fc_wren_o    = fc_wren_q;
    assign fc_waddr_o   = fc_waddr_q;
    assign fc_wdata_o   = fc_wdata_q;
    assign fc_done_o    = fc_done_q;
    assign done_o       = (state_q == S_DONE);
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_act_writeback.sv
// Randomized bench for act_writeback against a queue-based behavioural model plus directed scenarios.
module tb_act_writeback;
    localparam int N     = 16;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [N:0]        valid = '0;
    logic [N:0]        last = '0;
    logic [(N+1)*DW-1:0] data = '0;
    logic [N*AW-1:0]   addr = '0;
    logic              obuf_wren_o;
    logic [AW+3:0]     obuf_waddr_o;
    logic [DW-1:0]     obuf_wdata_o;
    logic              fc_wren_o;
    logic [6:0]        fc_waddr_o;
    logic [DW-1:0]     fc_wdata_o;
    logic              done_o, fc_done_o, overflow_o;
`ifdef ACT_WB_DROP_CNT_EN
    logic [15:0]       drop_cnt_o;
`endif

    act_writeback #(.LANE_NUM(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .act_valid_i(valid), .act_last_i(last),
        .act_result_i(data), .act_result_address_i(addr),
        .obuf_wren_o(obuf_wren_o), .obuf_waddr_o(obuf_waddr_o), .obuf_wdata_o(obuf_wdata_o),
        .fc_wren_o(fc_wren_o), .fc_waddr_o(fc_waddr_o), .fc_wdata_o(fc_wdata_o),
        .done_o(done_o), .fc_done_o(fc_done_o), .overflow_o(overflow_o)
`ifdef ACT_WB_DROP_CNT_EN
        , .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: queues per lane, phases of the layer, FC counter.
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;
    logic [17:0] mq [N][$];
    int          m_phase = P_IDLE, m_rr = 0, m_fc_cnt = 0, m_drops = 0;
    bit [N-1:0]  m_flags = '0;
    bit          m_ovf = 1'b0;
    logic        e_wren = 1'b0, e_fc_wren = 1'b0, e_fc_done = 1'b0, e_done = 1'b0;
    logic [13:0] e_waddr = '0;
    logic [7:0]  e_wdata = '0, e_fc_wdata = '0;
    logic [6:0]  e_fc_waddr = '0;

    always @(posedge clk) begin : model
        int sz [N];
        bit popped [N];
        int g;
        bit old_wren, anypush, act;
        bit [N-1:0] old_flags;
        logic [17:0] e;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_phase = P_IDLE; m_rr = 0; m_fc_cnt = 0; m_drops = 0; m_flags = '0; m_ovf = 1'b0;
            e_wren = 1'b0; e_fc_wren = 1'b0; e_fc_done = 1'b0; e_done = 1'b0;
        end else begin
            old_wren  = e_wren;
            old_flags = m_flags;
            act       = (m_phase == P_RUN) || (m_phase == P_DRAIN);
            g = -1;
            for (int i = 0; i < N; i++) begin sz[i] = mq[i].size(); popped[i] = 1'b0; end
            for (int k = 0; k < N; k++)
                if (g < 0 && sz[(m_rr + k) % N] > 0) g = (m_rr + k) % N;
            e_wren = (g >= 0);
            if (g >= 0) begin
                e = mq[g].pop_front();
                e_waddr = {4'(g), e[17:8]};
                e_wdata = e[7:0];
                popped[g] = 1'b1;
                m_rr = (g + 1) % N;
            end
            anypush = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (act && valid[i]) begin
                    if (sz[i] < DEPTH || popped[i]) begin
                        mq[i].push_back({addr[i*AW +: AW], data[i*DW +: DW]});
                        anypush = 1'b1;
                        if (last[i]) m_flags[i] = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
            end
            e_fc_wren = valid[N];
            e_fc_done = valid[N] && last[N];
            if (valid[N]) begin
                e_fc_waddr = 7'(m_fc_cnt);
                e_fc_wdata = data[N*DW +: DW];
                m_fc_cnt = last[N] ? 0 : (m_fc_cnt + 1) % 128;
            end
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase = P_RUN; m_flags = '0; m_ovf = 1'b0; m_drops = 0; m_fc_cnt = 0;
                end
                P_RUN: if (&old_flags) m_phase = P_DRAIN;
                P_DRAIN: begin
                    bit all_empty;
                    all_empty = 1'b1;
                    for (int i = 0; i < N; i++) if (sz[i] != 0) all_empty = 1'b0;
                    if (all_empty && !old_wren && !anypush) m_phase = P_DONE;
                end
                default: m_phase = P_IDLE;
            endcase
            e_done = (m_phase == P_DONE);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("obuf_wren", 32'(obuf_wren_o), 32'(e_wren));
            if (e_wren) begin
                chk("obuf_waddr", 32'(obuf_waddr_o), 32'(e_waddr));
                chk("obuf_wdata", 32'(obuf_wdata_o), 32'(e_wdata));
            end
            chk("fc_wren", 32'(fc_wren_o), 32'(e_fc_wren));
            if (e_fc_wren) begin
                chk("fc_waddr", 32'(fc_waddr_o), 32'(e_fc_waddr));
                chk("fc_wdata", 32'(fc_wdata_o), 32'(e_fc_wdata));
            end
            chk("fc_done", 32'(fc_done_o), 32'(e_fc_done));
            chk("done", 32'(done_o), 32'(e_done));
            chk("overflow", 32'(overflow_o), 32'(m_ovf));
`ifdef ACT_WB_DROP_CNT_EN
            chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drops));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        valid = '0;
        last  = '0;
        start = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid[i] = 1'b1;
        addr[i*AW +: AW] = a;
        data[i*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lanes [3];
        bit found;
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_obuf_wren", 32'(obuf_wren_o), 0);
        chk("rst_obuf_waddr", 32'(obuf_waddr_o), 0);
        chk("rst_fc_wren", 32'(fc_wren_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_overflow", 32'(overflow_o), 0);

        start = 1'b1; tick(); clr_in();

        // All 16 lanes in one cycle drain in lane order 0..15.
        for (int i = 0; i < N; i++) set_lane(i, AW'(i * 3), DW'(8'hA0 + i));
        tick(); clr_in();
        for (int i = 0; i < N; i++) begin
            tick();
            chk("burst_wren", 32'(obuf_wren_o), 1);
            chk("burst_lane", 32'(obuf_waddr_o[13:10]), 32'(i));
        end

        set_lane(3, 10'h012, 8'h5A);
        tick(); clr_in();
        tick();
        chk("lat2_wren", 32'(obuf_wren_o), 1);
        chk("lat2_waddr", 32'(obuf_waddr_o), 32'h0C12);
        chk("lat2_wdata", 32'(obuf_wdata_o), 32'h5A);

        // Pointer now sits after lane 3, so 7 and 9 precede 2.
        exp_lanes = '{7, 9, 2};
        set_lane(2, 10'h1, 8'h1); set_lane(7, 10'h2, 8'h2); set_lane(9, 10'h3, 8'h3);
        tick(); clr_in();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr_order", 32'(obuf_waddr_o[13:10]), 32'(exp_lanes[k]));
        end

        repeat (300) begin
            clr_in();
            start = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) set_lane(i, AW'($urandom), DW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                valid[N] = 1'b1;
                last[N]  = ($urandom_range(0, 15) == 0);
                data[N*DW +: DW] = DW'($urandom);
            end
            tick();
        end
        clr_in();
        repeat (40) tick();

        for (int i = 0; i < N; i++) begin
            set_lane(i, AW'($urandom), DW'($urandom));
            last[i] = 1'b1;
        end
        tick(); clr_in();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            tick();
            if (done_o) found = 1'b1;
        end
        chk("done_seen", 32'(found), 1);
        tick();
        chk("done_one_cycle", 32'(done_o), 0);

        set_lane(1, 10'h3FF, 8'hEE);
        tick(); clr_in();
        repeat (3) tick();
        chk("idle_valid_ignored", 32'(obuf_wren_o), 0);

        start = 1'b1; tick(); clr_in();
        chk("start_clears_ovf", 32'(overflow_o), 0);
        repeat (6) begin
            for (int i = 0; i < N; i++) set_lane(i, AW'($urandom), DW'($urandom));
            tick();
        end
        clr_in();
        chk("ovf_set", 32'(overflow_o), 1);
`ifdef ACT_WB_DROP_CNT_EN
        chk("drop_cnt_nonzero", 32'(drop_cnt_o != 16'd0), 1);
`endif
        repeat (120) tick();

        for (int w = 1; w <= 130; w++) begin
            valid[N] = 1'b1;
            last[N]  = (w == 130);
            data[N*DW +: DW] = DW'(w);
            tick(); clr_in();
            chk("fc_seq_waddr", 32'(fc_waddr_o), 32'((w - 1) % 128));
            chk("fc_seq_wren", 32'(fc_wren_o), 1);
            if (w == 130) chk("fc_done_last", 32'(fc_done_o), 1);
        end
        valid[N] = 1'b1;
        tick(); clr_in();
        chk("fc_after_done_addr", 32'(fc_waddr_o), 0);
        chk("fc_after_done_flag", 32'(fc_done_o), 0);

        set_lane(4, 10'h11, 8'h44); set_lane(5, 10'h22, 8'h55); set_lane(6, 10'h33, 8'h66);
        tick(); clr_in();
        rst = 1'b1;
        tick();
        chk("rst_mid_wren", 32'(obuf_wren_o), 0);
        chk("rst_mid_waddr", 32'(obuf_waddr_o), 0);
        chk("rst_mid_wdata", 32'(obuf_wdata_o), 0);
        chk("rst_mid_fc_wren", 32'(fc_wren_o), 0);
        chk("rst_mid_ovf", 32'(overflow_o), 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("post_rst_no_write", 32'(obuf_wren_o), 0);
        end
        start = 1'b1; tick(); clr_in();
        set_lane(8, 10'h055, 8'h77);
        tick(); clr_in();
        tick();
        chk("fresh_waddr", 32'(obuf_waddr_o), 32'({4'd8, 10'h055}));
        tick();
        chk("no_stale_entry", 32'(obuf_wren_o), 0);

        repeat (3) tick();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/act_writeback.md
ACT_WRITEBACK -- requirements
Module: act_writeback

Interface
REQ-001 SHALL have parameter LANE_NUM, default 16, number of conv activation lanes.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 10, per-lane ofmap address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, activation data width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, per-lane FIFO entries (power of 2).
REQ-005 SHALL have ports: clk  input  1  single clock, rising edge; rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports: start_i  input  1  begin layer; act_valid_i / act_last_i  input  1 x (LANE_NUM+1)  per-lane valid/last, index LANE_NUM = FC lane.
REQ-007 SHALL have ports: act_result_i  input  DATA_WIDTH x (LANE_NUM+1)  data; act_result_address_i  input  ADDRESS_WIDTH x LANE_NUM  conv lane address.
REQ-008 SHALL have ports: obuf_wren_o  output  1; obuf_waddr_o  output  ADDRESS_WIDTH+log2(LANE_NUM); obuf_wdata_o  output  DATA_WIDTH  ofmap buffer write.
REQ-009 SHALL have ports: fc_wren_o  output  1; fc_waddr_o  output  7; fc_wdata_o  output  DATA_WIDTH  FC result write.
REQ-010 SHALL have ports: done_o  output  1  conv layer done pulse; fc_done_o  output  1  FC done pulse; overflow_o  output  1  sticky drop flag.

Function
REQ-011 SHALL run FSM IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_i; start_i ignored outside IDLE.
REQ-012 SHALL on IDLE->RUN clear all lane last-flags, overflow_o and FC address counter.
REQ-013 SHALL push conv lane i (valid data, address) into FIFO i only in RUN or DRAIN; valid in IDLE/DONE ignored, not flagged.
REQ-014 SHALL accept push on full FIFO only when same-cycle pop on that lane; otherwise drop entry and set overflow_o.
REQ-015 SHALL set lane i last-flag when accepted act_valid_i[i] with act_last_i[i]; RUN->DRAIN when all LANE_NUM flags set.
REQ-016 SHALL grant one non-empty FIFO per cycle, round-robin, priority starting at lane after last grant (lane 0 after reset).
REQ-017 SHALL register write outputs: obuf_waddr_o = {lane index, address}, obuf_wdata_o = data, obuf_wren_o = 1 for one cycle per grant.
REQ-018 SHALL give latency 2: input sampled at edge E0 on empty FIFO with no contention -> obuf_wren_o high in cycle after E1.
REQ-019 SHALL DRAIN->DONE when all FIFOs empty and no write pending; DONE asserts done_o for exactly one cycle, then IDLE.
REQ-020 SHALL bypass FC lane (no FIFO): registered fc_wren_o/fc_wdata_o one cycle after act_valid_i[LANE_NUM], in any state.
REQ-021 SHALL use fc_waddr_o = FC counter value, counter increments per FC write, wraps 127->0.
REQ-022 SHALL on FC write with act_last_i[LANE_NUM] pulse fc_done_o with that write and reset FC counter to 0.

Reset
REQ-023 SHALL on rst: FSM IDLE, FIFOs empty, RR pointer lane 0, all outputs 0 (obuf/fc write ports, done_o, fc_done_o, overflow_o).
REQ-024 SHALL on rst mid-operation discard all buffered entries without issuing writes.

Configuration
REQ-025 SHALL, with ACT_WB_DROP_CNT_EN defined, add output drop_cnt_o (16 bit) counting dropped entries, saturating at 0xFFFF, cleared on rst and IDLE->RUN.
REQ-026 SHALL, without ACT_WB_DROP_CNT_EN, omit drop_cnt_o and its logic; overflow_o behaviour unchanged.

Verification
REQ-027 SHALL cover: start, lane 3 valid data 0x5A addr 0x012 -> obuf write addr {3,0x012}=0x0C12, data 0x5A, 2 cycles later.
REQ-028 SHALL cover: all 16 lanes valid same cycle -> 16 consecutive writes, lane order 0..15, then next burst starts after last granted lane.
REQ-029 SHALL cover: lane 0 valid 6 consecutive cycles while other 15 lanes saturate arbiter -> overflow_o=1 (drop_cnt_o>0 with macro).
REQ-030 SHALL cover: all lanes send last -> DRAIN, FIFOs empty -> done_o single-cycle pulse, FSM IDLE.
REQ-031 SHALL cover: 130 FC writes, last on final -> fc_waddr_o 0..127,0,1, fc_done_o on write 130, counter then 0.
REQ-032 SHALL cover: rst asserted with 3 entries buffered -> no obuf writes after reset, all outputs 0.
